// File: rtl/muldiv_scheduler.sv
// Sequencer between the DX stage and an iterative multdiv unit: accepts one
// mult/div at a time, launches it, waits for the result (or a watchdog
// timeout) and then competes with the MW stage for the regfile write port.
module muldiv_scheduler #(
  parameter int MAX_CYCLES = 40,
  parameter int STATUS_REG = 30,
  parameter int MULT_EXC   = 4,
  parameter int DIV_EXC    = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  src_rega,
  input  logic [4:0]  src_regb,
  input  logic        wb_busy,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        commit_valid,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_data
);

  typedef enum logic [1:0] {IDLE, START, BUSY, COMMIT} state_t;

  localparam logic [4:0]  STATUS_IDX = 5'(STATUS_REG);
  localparam logic [31:0] MULT_CODE  = 32'(MULT_EXC);
  localparam logic [31:0] DIV_CODE   = 32'(DIV_EXC);
  localparam logic [5:0]  WD_LAST    = 6'(MAX_CYCLES - 1);

  state_t     state;
  logic       op_q;
  logic [4:0] rd_q;
  logic       exc_q;
  logic [5:0] wd_count;
  logic       raw_hazard;

  // A DX instruction reading the pending destination must wait for the commit
  always_comb begin
    raw_hazard = (rd_q != 5'd0) && ((src_rega == rd_q) || (src_regb == rd_q));
    stall      = (state != IDLE) && (issue_valid || raw_hazard);
  end

  // Write-port request; the MW stage has priority and r0 results are dropped
  always_comb begin
    commit_valid = (state == COMMIT) && !wb_busy && (exc_q || (rd_q != 5'd0));
  end

  // Operation sequencing, operand/result latching and watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= 1'b0;
      rd_q        <= 5'd0;
      exc_q       <= 1'b0;
      wd_count    <= 6'd0;
      md_a        <= 32'd0;
      md_b        <= 32'd0;
      ctrl_mult   <= 1'b0;
      ctrl_div    <= 1'b0;
      commit_rd   <= 5'd0;
      commit_data <= 32'd0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid) begin
            md_a      <= issue_a;
            md_b      <= issue_b;
            op_q      <= issue_op;
            rd_q      <= issue_rd;
            exc_q     <= 1'b0;
            ctrl_mult <= !issue_op;
            ctrl_div  <= issue_op;
            state     <= START;
          end
        end
        START: begin
          wd_count <= 6'd0;
          state    <= BUSY;
        end
        BUSY: begin
          wd_count <= wd_count + 6'd1;
          if (md_ready) begin
            exc_q <= md_exception;
            state <= COMMIT;
            if (md_exception) begin
              commit_rd   <= STATUS_IDX;
              commit_data <= op_q ? DIV_CODE : MULT_CODE;
            end else begin
              commit_rd   <= rd_q;
              commit_data <= md_result;
            end
          end else if (wd_count == WD_LAST) begin
            exc_q       <= 1'b1;
            commit_rd   <= STATUS_IDX;
            commit_data <= op_q ? DIV_CODE : MULT_CODE;
            state       <= COMMIT;
          end
        end
        COMMIT: begin
          if (!wb_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_scheduler.md
MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 Parameter MAX_CYCLES, default 40: watchdog limit in cycles from operation start to md_ready.
REQ-002 Parameter STATUS_REG, default 30: register index written on exception.
REQ-003 Parameter MULT_EXC, default 4: status code written on multiply exception.
REQ-004 Parameter DIV_EXC, default 5: status code written on divide exception.
REQ-005 The port list SHALL be as follows, one port per line as name, direction, width, meaning:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high.
- issue_valid, in, 1: the DX-stage instruction is a mult or div.
- issue_op, in, 1: 0 selects mult, 1 selects div.
- issue_a, in, 32: operand A, already bypassed.
- issue_b, in, 32: operand B, already bypassed.
- issue_rd, in, 5: destination register.
- src_rega, in, 5: source register A of the DX instruction, used for the hazard check.
- src_regb, in, 5: source register B of the DX instruction, used for the hazard check.
- wb_busy, in, 1: the pipeline MW stage is using the regfile write port this cycle.
- md_a, out, 32: latched operand A to the multdiv unit.
- md_b, out, 32: latched operand B to the multdiv unit.
- ctrl_mult, out, 1: one-cycle start pulse for multiply.
- ctrl_div, out, 1: one-cycle start pulse for divide.
- md_result, in, 32: multdiv result.
- md_exception, in, 1: multdiv exception, valid with md_ready.
- md_ready, in, 1: multdiv result valid.
- stall, out, 1: hold PC, FD and DX.
- commit_valid, out, 1: write-port request to the regfile.
- commit_rd, out, 5: write register for the commit.
- commit_data, out, 32: write data for the commit.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, START, BUSY and COMMIT.
REQ-007 IDLE with issue_valid=1: latch issue_a, issue_b, issue_op and issue_rd, and go to START; stall=0.
REQ-008 START: assert ctrl_mult (op=0) or ctrl_div (op=1) for exactly this one cycle, clear the watchdog counter, and go to BUSY.
REQ-009 md_a and md_b SHALL hold the latched operands from START until the FSM returns to IDLE.
REQ-010 BUSY: increment the 6-bit watchdog counter each cycle.
REQ-011 BUSY with md_ready=1: latch md_result and md_exception, and go to COMMIT.
REQ-012 BUSY with the counter reaching MAX_CYCLES before md_ready: latch an exception and go to COMMIT.
REQ-013 COMMIT with wb_busy=0: assert commit_valid for one cycle, then go to IDLE.
REQ-014 COMMIT with wb_busy=1: hold COMMIT with commit_valid=0; the pipeline write port always wins.
REQ-015 On a normal commit: commit_rd = latched rd and commit_data = latched result.
REQ-016 On an exception commit: commit_rd = STATUS_REG and commit_data = MULT_EXC or DIV_EXC, zero-extended to 32 bits.
REQ-017 A normal commit with latched rd=0 SHALL keep commit_valid=0 and still return to IDLE; an exception commit is never suppressed.
REQ-018 stall=1 whenever the state is not IDLE and issue_valid=1 (structural hazard: one operation in flight).
REQ-019 stall=1 whenever the state is not IDLE and either src_rega or src_regb equals the latched rd with latched rd≠0 (RAW hazard).
REQ-020 stall SHALL be 0 in every other case; stall is combinational from state, latches and inputs.
REQ-021 issue_valid in COMMIT SHALL stall; the new operation is accepted in the IDLE cycle that follows commit_valid.
REQ-022 Issue-to-commit latency SHALL be 2 + N + 1 cycles, where N is the number of BUSY cycles, with wb_busy=0.
REQ-023 md_ready outside BUSY SHALL be ignored.
REQ-024 md_result SHALL be sampled only on the md_ready cycle.

Reset
REQ-025 reset SHALL force, asynchronously: state=IDLE, all latches and the counter to 0, and ctrl_mult, ctrl_div, stall and commit_valid to 0.
REQ-026 reset SHALL force md_a, md_b, commit_rd and commit_data to 0.
REQ-027 reset asserted mid-operation SHALL discard the operation with no commit.
REQ-028 The first issue after reset deassertion SHALL be accepted normally.

Verification
REQ-029 Multiply: issue mult 6×7, rd=5; ready after 17 BUSY cycles -> a single ctrl_mult pulse, commit_rd=5, commit_data=42, latency 20 cycles.
REQ-030 Divide by zero: issue div 9/0, rd=3; md_exception=1 with ready -> commit_rd=30, commit_data=5.
REQ-031 Write-port contention: wb_busy held high for 3 cycles in COMMIT -> commit_valid deferred exactly 3 cycles, data unchanged.
REQ-032 RAW hazard: while BUSY with rd=8, src_rega=8 -> stall=1; src_rega=9 with issue_valid=0 -> stall=0; rd=0 with src_rega=0 -> stall=0.
REQ-033 Watchdog: md_ready never asserted on a mult -> after 40 BUSY cycles, commit to r30 with value 4.
REQ-034 Reset mid-operation: reset asserted in BUSY -> all outputs 0 immediately, no commit; a following issue completes correctly.
